dsp_sched: RTL
==============

Name: dsp_sched

Overview:
Sequencer/configurator for the shared-LO 4-channel DDC + CORDIC pipeline (dsp). Accepts host writes of LO frequency word and CIC decimation and applies them only at a frame boundary. After each apply it resets the pipeline, discards settling frames, then forwards valid frame strobes to the consumer via a valid/ready handshake. Sits between the CSR bank and dsp; also flags overflow and stall.

Parameters:
FTW_INIT, 32'h0, dds_ftw value after reset
DECIM_INIT, 13'd256, decimation value after reset
DECIM_MIN, 13'd16, smallest decimation ever driven; lower writes are clamped up
RST_CYC, 4, cycles dsp_reset is held high per apply
N_SETTLE, 3, out_strobe frames discarded after each apply (0 allowed)
PEND_TMO, 16384, max cycles waiting for a frame boundary before forcing apply
WD_CYC, 65535, cycles without out_strobe in SETTLE/RUN that raise stall

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
cfg_ftw  in  32  requested LO frequency tuning word
cfg_decim  in  13  requested decimation
cfg_wr  in  1  one-cycle write request; samples cfg_ftw/cfg_decim
cfg_busy  out  1  high in PEND and RESET states
cfg_rej  out  1  sticky: cfg_wr arrived while cfg_busy; cleared by next accepted cfg_wr
dds_ftw  out  32  to dsp
decimation  out  13  to dsp
dsp_reset  out  1  active-high synchronous reset to dsp
out_strobe  in  1  frame-complete pulse from dsp
frame_valid  out  1  new frame available on dsp outputs
frame_ready  in  1  consumer accepts frame
frame_seq  out  16  sequence number of presented frame
ovf_cnt  out  8  saturating count of dropped frames
stall  out  1  sticky watchdog flag
locked  out  1  high in RUN

Behaviour:
- Async reset (reset_n=0): state=RESET, dds_ftw=FTW_INIT, decimation=max(DECIM_INIT,DECIM_MIN), dsp_reset=1, rst counter=0, frame_valid=0, frame_seq=0, ovf_cnt=0, stall=0, cfg_rej=0, locked=0, cfg_busy=1. Deassertion: RESET sequence runs as after an apply.
- States: RESET -> SETTLE -> RUN; RUN/SETTLE --cfg_wr--> PEND -> RESET.
- cfg_wr in RUN or SETTLE: shadow <= {cfg_ftw, max(cfg_decim,DECIM_MIN)}, cfg_rej<=0, go PEND next cycle. cfg_wr while cfg_busy: ignored, cfg_rej<=1.
- PEND: frame_valid forced 0, pending frame abandoned (no ovf). Leave on first out_strobe, or when PEND counter reaches PEND_TMO-1 (counts from PEND entry); cfg_wr is rejected.
- RESET entry cycle (registered): dds_ftw/decimation <= shadow; dsp_reset=1 for exactly RST_CYC cycles; stall<=0; watchdog cleared. Then SETTLE, dsp_reset=0.
- SETTLE: count out_strobe; on the N_SETTLE-th go RUN (N_SETTLE=0: straight to RUN on next cycle). Strobes never forwarded.
- RUN, locked=1: out_strobe with frame_valid=0 or frame_ready=1 same cycle -> frame_valid=1 next cycle, frame_seq+=1 (wraps 16'hFFFF->0). out_strobe while frame_valid=1 and frame_ready=0 -> frame dropped, frame_valid stays, frame_seq unchanged, ovf_cnt+=1 saturating at 255.
- frame_valid&frame_ready with no out_strobe -> frame_valid=0 next cycle. Handshake: frame_valid held until accepted.
- Watchdog: counter reset on out_strobe/state entry; counts in SETTLE and RUN; at WD_CYC stall<=1 (sticky until next apply); no state change.
- frame_seq and ovf_cnt cleared only by reset_n.

Decomposition:
- Shared package dsp_pkg: state encoding constants (S_RESET, S_SETTLE, S_RUN, S_PEND), FTW/decimation widths (32/13), shared with dsp and CSR map.
- One sub-module: sat_cnt (parametric saturating counter, width/increment/clear) used for ovf_cnt and watchdog.

Test Plan:
- Release reset_n -> dsp_reset high 4 cycles, dds_ftw=0, decimation=256; 3 out_strobe ignored; 4th -> frame_valid=1, frame_seq=1, locked=1.
- In RUN, cfg_wr ftw=32'h1234_5678 decim=100 -> cfg_busy=1; next out_strobe -> dds_ftw=32'h12345678, decimation=100, dsp_reset 4 cycles, locked=0 until 3 settle frames pass.
- cfg_wr decim=5 -> decimation=16; second cfg_wr during PEND -> ignored, cfg_rej=1, shadow retains first value.
- RUN, frame_ready=0, 300 out_strobes -> frame_seq=1 held, ovf_cnt saturates at 255; frame_ready=1 one cycle -> frame_valid drops.
- PEND with out_strobe tied 0 -> forced apply after 16384 cycles; in RUN no strobe for 65535 cycles -> stall=1, cleared by next apply.
- reset_n low mid-SETTLE -> all outputs to reset values asynchronously, shadow discarded, dds_ftw back to FTW_INIT.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared definitions for the DDC/CORDIC pipeline sequencer: state encoding,
// configuration word widths and the decimation clamp helper.
package dsp_pkg;
  localparam int FTW_W   = 32;
  localparam int DECIM_W = 13;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2,
    S_PEND   = 2'd3
  } state_e;

  typedef struct packed {
    logic [FTW_W-1:0]   ftw;
    logic [DECIM_W-1:0] decim;
  } cfg_t;

  function automatic logic [DECIM_W-1:0] decim_clamp(input logic [DECIM_W-1:0] d,
                                                     input logic [DECIM_W-1:0] mn);
    return (d < mn) ? mn : d;
  endfunction
endpackage

// File: rtl/dsp_sched_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_cnt #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255,
  parameter int INC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(INC);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (inc && cnt_q >= MAXV - STEP) cnt_d = MAXV;
    else if (inc)                 cnt_d = cnt_q + STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/dsp_sched.sv
// Sequencer for the shared-LO DDC pipeline: applies host config at frame
// boundaries, resets and settles the pipeline, then hands frames to a consumer.
module dsp_sched
  import dsp_pkg::*;
#(
  parameter logic [FTW_W-1:0]   FTW_INIT   = 32'h0,
  parameter logic [DECIM_W-1:0] DECIM_INIT = 13'd256,
  parameter logic [DECIM_W-1:0] DECIM_MIN  = 13'd16,
  parameter int                 RST_CYC    = 4,
  parameter int                 N_SETTLE   = 3,
  parameter int                 PEND_TMO   = 16384,
  parameter int                 WD_CYC     = 65535
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [FTW_W-1:0]   cfg_ftw,
  input  logic [DECIM_W-1:0] cfg_decim,
  input  logic               cfg_wr,
  output logic               cfg_busy,
  output logic               cfg_rej,
  output logic [FTW_W-1:0]   dds_ftw,
  output logic [DECIM_W-1:0] decimation,
  output logic               dsp_reset,
  input  logic               out_strobe,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [15:0]        frame_seq,
  output logic [7:0]         ovf_cnt,
  output logic               stall,
  output logic               locked
);
  localparam int RW = $clog2(RST_CYC + 1);
  localparam int SW = (N_SETTLE > 0) ? $clog2(N_SETTLE + 1) : 1;
  localparam int PW = $clog2(PEND_TMO + 1);
  localparam int WW = $clog2(WD_CYC + 1);
  localparam cfg_t CFG_RST = '{ftw: FTW_INIT,
                               decim: (DECIM_INIT < DECIM_MIN) ? DECIM_MIN : DECIM_INIT};

  state_e          state_q, state_d;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [PW-1:0]   pend_cnt_q, pend_cnt_d;
  cfg_t            shadow_q, shadow_d, live_q, live_d;
  logic            rej_q, rej_d, stall_q, stall_d, fv_q, fv_d;
  logic [15:0]     seq_q, seq_d;
  logic            drop, active, wd_clr;
  logic [WW-1:0]   wd_cnt;

  assign active = (state_q == S_SETTLE) || (state_q == S_RUN);

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    settle_cnt_d = settle_cnt_q;
    pend_cnt_d   = pend_cnt_q;
    shadow_d     = shadow_q;
    live_d       = live_q;
    rej_d        = rej_q;
    stall_d      = stall_q;
    fv_d         = fv_q;
    seq_d        = seq_q;
    drop         = 1'b0;

    case (state_q)
      S_RESET: begin
        if (rst_cnt_q == RW'(RST_CYC - 1)) begin
          state_d      = S_SETTLE;
          settle_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (N_SETTLE == 0) state_d = S_RUN;
        else if (out_strobe) begin
          if (settle_cnt_q == SW'(N_SETTLE - 1)) state_d = S_RUN;
          else settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      S_PEND: begin
        // Apply at the frame boundary, or give up waiting and force it.
        if (out_strobe || pend_cnt_q == PW'(PEND_TMO - 1)) begin
          state_d   = S_RESET;
          rst_cnt_d = '0;
          live_d    = shadow_q;
          stall_d   = 1'b0;
        end else begin
          pend_cnt_d = pend_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (cfg_wr) begin
      if (active) begin
        shadow_d   = '{ftw: cfg_ftw, decim: decim_clamp(cfg_decim, DECIM_MIN)};
        rej_d      = 1'b0;
        state_d    = S_PEND;
        pend_cnt_d = '0;
      end else begin
        rej_d = 1'b1;
      end
    end

    if (active && wd_cnt == WW'(WD_CYC)) stall_d = 1'b1;

    // Frames are only forwarded while staying in RUN; leaving RUN abandons them.
    if (state_q == S_RUN && state_d == S_RUN) begin
      if (out_strobe) begin
        if (!fv_q || frame_ready) begin
          fv_d  = 1'b1;
          seq_d = seq_q + 16'd1;
        end else begin
          drop = 1'b1;
        end
      end else if (fv_q && frame_ready) begin
        fv_d = 1'b0;
      end
    end else begin
      fv_d = 1'b0;
    end
  end

  assign wd_clr = out_strobe || !active || (state_d != state_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_RESET;
      rst_cnt_q    <= '0;
      settle_cnt_q <= '0;
      pend_cnt_q   <= '0;
      shadow_q     <= CFG_RST;
      live_q       <= CFG_RST;
      rej_q        <= 1'b0;
      stall_q      <= 1'b0;
      fv_q         <= 1'b0;
      seq_q        <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      pend_cnt_q   <= pend_cnt_d;
      shadow_q     <= shadow_d;
      live_q       <= live_d;
      rej_q        <= rej_d;
      stall_q      <= stall_d;
      fv_q         <= fv_d;
      seq_q        <= seq_d;
    end
  end

  sat_cnt #(.WIDTH(8), .MAX(255), .INC(1)) u_ovf (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (1'b0),
    .inc   (drop),
    .cnt   (ovf_cnt)
  );

  sat_cnt #(.WIDTH(WW), .MAX(WD_CYC), .INC(1)) u_wd (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (wd_clr),
    .inc   (active),
    .cnt   (wd_cnt)
  );

  assign cfg_busy    = (state_q == S_PEND) || (state_q == S_RESET);
  assign cfg_rej     = rej_q;
  assign dds_ftw     = live_q.ftw;
  assign decimation  = live_q.decim;
  assign dsp_reset   = (state_q == S_RESET);
  assign frame_valid = fv_q;
  assign frame_seq   = seq_q;
  assign stall       = stall_q;
  assign locked      = (state_q == S_RUN);
endmodule
